tt_dfd_skid_buffer_clr: RTL and testbench
=========================================

// Module: tt_dfd_skid_buffer_clr
//
// PURPOSE
// - Two-entry valid/ready skid buffer with synchronous flush; the registered pipeline stage between
//   a DFD trace/debug producer and its consumer, built on clearable-flop semantics (en/clr).
// - Full throughput (1 beat/cycle), all outputs registered incl. in_rdy; cuts timing on both
//   data and back-pressure paths. clr drops all buffered beats, as in a flush or trace restart.
//
// PARAMETERS
// - WIDTH        8   payload width in bits
// - RESET_VALUE  0   value of both data registers (and out_data) after reset and after clr
//
// PORTS
// - clk        in   1      clock; single clock domain
// - rst_n      in   1      asynchronous active-low reset
// - clr        in   1      synchronous flush; highest priority
// - in_vld     in   1      upstream beat valid
// - in_rdy     out  1      registered; buffer can take a beat this cycle
// - in_data    in   WIDTH  upstream payload
// - out_vld    out  1      registered; downstream beat valid
// - out_rdy    in   1      downstream accepts
// - out_data   out  WIDTH  registered payload (main entry)
// - stall_cnt  out  16     only with TT_DFD_SKID_BUF_STALL_CNT_EN
//
// BEHAVIOUR
// - Handshake: beat transfers when vld&rdy same cycle. in_vld may be raised regardless of in_rdy;
//   out_vld/out_data hold stable until out_rdy. No combinational in->out path.
// - Storage: main entry (drives out_*) + skid entry. State = {main_vld, skid_vld}:
//   EMPTY(0,0), ONE(1,0), FULL(1,1); (0,1) is illegal -> assertion.
// - in_rdy = ~skid_vld (registered). out_vld = main_vld.
// - Transitions (push = in_vld&in_rdy, pop = out_vld&out_rdy):
//   EMPTY: push -> ONE, main<=in_data.
//   ONE: push&pop -> ONE, main<=in_data; push&~pop -> FULL, skid<=in_data; pop&~push -> EMPTY.
//   FULL: pop -> ONE, main<=skid (no push possible, in_rdy=0); ~pop -> FULL hold.
// - Latency: in->out 1 cycle when EMPTY/ONE-with-pop. Order strictly FIFO; no loss, no duplication.
// - Throughput: continuous in_vld with out_rdy=1 -> 1 beat/cycle, never enters FULL.
// - clr (any state): next cycle EMPTY, in_rdy=1, out_vld=0, both data regs=RESET_VALUE.
//   A push or pop coincident with clr is discarded (upstream push counted as accepted but dropped;
//   pop completes from consumer's view). clr overrides push/pop.
// - Reset (async, any time incl. mid-transfer): EMPTY, in_rdy=1, out_vld=0,
//   out_data=RESET_VALUE, skid data=RESET_VALUE. First cycle after deassert behaves as EMPTY.
// - Data regs enable only on load/clr (gated-flop friendly); state bits enable every cycle.
//
// CONFIGURATION
// - TT_DFD_SKID_BUF_STALL_CNT_EN defined: port stall_cnt[15:0] present; increments each cycle
//   out_vld & ~out_rdy; saturates at 16'hFFFF; reset to 0 by rst_n and by clr (clr wins over incr).
// - Not defined: stall_cnt port and counter absent; datapath behaviour identical.
//
// TESTING
// - Reset: hold rst_n=0 with in_vld=1 -> in_rdy=1, out_vld=0, out_data=RESET_VALUE; no beat accepted.
// - Streaming: 32 beats 0x00..0x1F, out_rdy=1 -> out sequence 0x00..0x1F, 1/cycle, 1-cycle latency.
// - Back-pressure: push 0xA1,0xA2 with out_rdy=0 -> FULL, in_rdy=0, out_data=0xA1 held; release
//   out_rdy -> 0xA1 then 0xA2 out, in_rdy=1 cycle after first pop.
// - Flush: FULL with 0xB1/0xB2, assert clr with in_vld=1 data 0xB3 -> next cycle EMPTY, out_vld=0,
//   out_data=RESET_VALUE; 0xB3 never appears at output.
// - Random: random in_vld/out_rdy 10k cycles vs scoreboard -> in-order, no drop/dup; (0,1) never hit.
// - Macro on: out_vld=1,out_rdy=0 for 5 cycles -> stall_cnt=5; force 70000 stalls -> 16'hFFFF; clr -> 0.

Source files
------------

// File: rtl/tt_dfd_skid_buffer_clr.sv
// Two-entry registered valid/ready skid buffer with synchronous flush (clr).
// Optional stall counter enabled by defining TT_DFD_SKID_BUF_STALL_CNT_EN.
module tt_dfd_skid_buffer_clr #(
    parameter int unsigned           WIDTH       = 8,
    parameter logic [WIDTH-1:0]      RESET_VALUE = '0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             in_vld,
    output logic             in_rdy,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_vld,
    input  logic             out_rdy,
    output logic [WIDTH-1:0] out_data
`ifdef TT_DFD_SKID_BUF_STALL_CNT_EN
    ,
    output logic [15:0]      stall_cnt
`endif
);

    // Encoding is {main_vld, skid_vld}; 2'b01 is unreachable.
    typedef enum logic [1:0] {
        EMPTY = 2'b00,
        ONE   = 2'b10,
        FULL  = 2'b11
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [WIDTH-1:0] main_data;
    logic [WIDTH-1:0] skid_data;
    logic             push;
    logic             pop;
    logic             main_ld;
    logic             main_from_skid;
    logic             skid_ld;

    assign in_rdy   = ~state[0];
    assign out_vld  = state[1];
    assign out_data = main_data;

    assign push = in_vld & in_rdy;
    assign pop  = out_vld & out_rdy;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= EMPTY;
        end else if (clr) begin
            state <= EMPTY;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt      = state;
        main_ld        = 1'b0;
        main_from_skid = 1'b0;
        skid_ld        = 1'b0;
        unique case (state)
            EMPTY: begin
                if (push) begin
                    state_nxt = ONE;
                    main_ld   = 1'b1;
                end
            end
            ONE: begin
                if (push && pop) begin
                    main_ld = 1'b1;
                end else if (push) begin
                    state_nxt = FULL;
                    skid_ld   = 1'b1;
                end else if (pop) begin
                    state_nxt = EMPTY;
                end
            end
            FULL: begin
                if (pop) begin
                    state_nxt      = ONE;
                    main_ld        = 1'b1;
                    main_from_skid = 1'b1;
                end
            end
            default: state_nxt = EMPTY;
        endcase
    end

    // Data registers only load on a beat or a flush, so they map onto enable flops.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            main_data <= RESET_VALUE;
        end else if (clr) begin
            main_data <= RESET_VALUE;
        end else if (main_ld) begin
            main_data <= main_from_skid ? skid_data : in_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            skid_data <= RESET_VALUE;
        end else if (clr) begin
            skid_data <= RESET_VALUE;
        end else if (skid_ld) begin
            skid_data <= in_data;
        end
    end

`ifdef TT_DFD_SKID_BUF_STALL_CNT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt <= '0;
        end else if (clr) begin
            stall_cnt <= '0;
        end else if (out_vld && !out_rdy && (stall_cnt != '1)) begin
            stall_cnt <= stall_cnt + 16'd1;
        end
    end
`endif

    a_no_skid_without_main: assert property (
        @(posedge clk) disable iff (!rst_n) state != state_t'(2'b01)
    );

endmodule

// File: tb/tb_tt_dfd_skid_buffer_clr.sv
// Directed and randomised checks for tt_dfd_skid_buffer_clr against a queue model.
module tb_tt_dfd_skid_buffer_clr;

    localparam int unsigned WIDTH = 8;

    logic             clk;
    logic             rst_n;
    logic             clr;
    logic             in_vld;
    logic             in_rdy;
    logic [WIDTH-1:0] in_data;
    logic             out_vld;
    logic             out_rdy;
    logic [WIDTH-1:0] out_data;
`ifdef TT_DFD_SKID_BUF_STALL_CNT_EN
    logic [15:0]      stall_cnt;
`endif

    int unsigned n_cmp;
    int unsigned n_err;

    tt_dfd_skid_buffer_clr #(
        .WIDTH       (WIDTH),
        .RESET_VALUE (8'h00)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .clr       (clr),
        .in_vld    (in_vld),
        .in_rdy    (in_rdy),
        .in_data   (in_data),
        .out_vld   (out_vld),
        .out_rdy   (out_rdy),
        .out_data  (out_data)
`ifdef TT_DFD_SKID_BUF_STALL_CNT_EN
        ,
        .stall_cnt (stall_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    logic [WIDTH-1:0] q[$];
    logic [WIDTH-1:0] exp_d;
    bit               do_push;
    bit               do_pop;

    initial begin
        n_cmp   = 0;
        n_err   = 0;
        rst_n   = 1'b0;
        clr     = 1'b0;
        in_vld  = 1'b1;
        in_data = 8'h55;
        out_rdy = 1'b0;

        // Reset held with in_vld high
        repeat (3) tick();
        check("rst_in_rdy", 32'(in_rdy), 32'd1);
        check("rst_out_vld", 32'(out_vld), 32'd0);
        check("rst_out_data", 32'(out_data), 32'h00);
        rst_n  = 1'b1;
        in_vld = 1'b0;
        tick();
        check("post_rst_out_vld", 32'(out_vld), 32'd0);
        check("post_rst_in_rdy", 32'(in_rdy), 32'd1);

        // Streaming 0x00..0x1F at full rate
        out_rdy = 1'b1;
        in_vld  = 1'b1;
        for (int i = 0; i < 32; i++) begin
            in_data = 8'(i);
            tick();
            check("stream_vld", 32'(out_vld), 32'd1);
            check("stream_data", 32'(out_data), 32'(i));
            check("stream_in_rdy", 32'(in_rdy), 32'd1);
        end
        in_vld = 1'b0;
        tick();
        check("stream_drain_vld", 32'(out_vld), 32'd0);

        // Back-pressure into FULL, then release
        out_rdy = 1'b0;
        in_vld  = 1'b1;
        in_data = 8'hA1;
        tick();
        check("bp_one_vld", 32'(out_vld), 32'd1);
        check("bp_one_data", 32'(out_data), 32'hA1);
        check("bp_one_in_rdy", 32'(in_rdy), 32'd1);
        in_data = 8'hA2;
        tick();
        check("bp_full_in_rdy", 32'(in_rdy), 32'd0);
        check("bp_full_data", 32'(out_data), 32'hA1);
        in_vld  = 1'b0;
        in_data = 8'hEE;
        tick();
        check("bp_hold_in_rdy", 32'(in_rdy), 32'd0);
        check("bp_hold_data", 32'(out_data), 32'hA1);
        check("bp_hold_vld", 32'(out_vld), 32'd1);
        out_rdy = 1'b1;
        tick();
        check("bp_pop1_data", 32'(out_data), 32'hA2);
        check("bp_pop1_vld", 32'(out_vld), 32'd1);
        check("bp_pop1_in_rdy", 32'(in_rdy), 32'd1);
        tick();
        check("bp_pop2_vld", 32'(out_vld), 32'd0);

        // Flush from FULL with a coincident push
        out_rdy = 1'b0;
        in_vld  = 1'b1;
        in_data = 8'hB1;
        tick();
        in_data = 8'hB2;
        tick();
        check("fl_full_in_rdy", 32'(in_rdy), 32'd0);
        in_data = 8'hB3;
        clr     = 1'b1;
        tick();
        check("fl_out_vld", 32'(out_vld), 32'd0);
        check("fl_in_rdy", 32'(in_rdy), 32'd1);
        check("fl_out_data", 32'(out_data), 32'h00);
        clr    = 1'b0;
        in_vld = 1'b0;
        out_rdy = 1'b1;
        tick();
        check("fl_b3_dropped", 32'(out_vld), 32'd0);
        // Skid entry must also have been cleared: fill then drain shows only new beats
        out_rdy = 1'b0;
        in_vld  = 1'b1;
        in_data = 8'hC1;
        tick();
        in_data = 8'hC2;
        tick();
        in_vld  = 1'b0;
        out_rdy = 1'b1;
        tick();
        check("fl_refill_skid", 32'(out_data), 32'hC2);
        tick();
        check("fl_refill_empty", 32'(out_vld), 32'd0);

        // Random traffic against a queue model
        q.delete();
        for (int c = 0; c < 10000; c++) begin
            in_vld  = 1'($urandom_range(0, 1));
            in_data = 8'($urandom);
            out_rdy = 1'($urandom_range(0, 3) != 0);
            check("rnd_in_rdy", 32'(in_rdy), 32'(q.size() < 2));
            check("rnd_out_vld", 32'(out_vld), 32'(q.size() > 0));
            do_pop  = (q.size() > 0) && out_rdy;
            do_push = in_vld && (q.size() < 2);
            if (do_pop) begin
                exp_d = q.pop_front();
                check("rnd_data", 32'(out_data), 32'(exp_d));
            end
            if (do_push) q.push_back(in_data);
            tick();
        end
        in_vld  = 1'b0;
        out_rdy = 1'b1;
        for (int c = 0; c < 4; c++) begin
            if (q.size() > 0) begin
                check("rnd_drain_vld", 32'(out_vld), 32'd1);
                exp_d = q.pop_front();
                check("rnd_drain_data", 32'(out_data), 32'(exp_d));
            end
            tick();
        end
        check("rnd_final_empty", 32'(out_vld), 32'd0);

`ifdef TT_DFD_SKID_BUF_STALL_CNT_EN
        clr = 1'b1;
        tick();
        clr = 1'b0;
        check("sc_clr0", 32'(stall_cnt), 32'd0);
        out_rdy = 1'b0;
        in_vld  = 1'b1;
        in_data = 8'hD1;
        tick();
        in_vld = 1'b0;
        check("sc_first", 32'(stall_cnt), 32'd0);
        repeat (5) tick();
        check("sc_five", 32'(stall_cnt), 32'd5);
        repeat (70000) tick();
        check("sc_sat", 32'(stall_cnt), 32'hFFFF);
        clr = 1'b1;
        tick();
        clr = 1'b0;
        check("sc_clr", 32'(stall_cnt), 32'd0);
        check("sc_clr_vld", 32'(out_vld), 32'd0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
